axis_frame_gen: RTL and testbench

AXI4-Stream frame transmitter that drives frames of programmable length and deterministic byte pattern into the slave side of a stream FIFO or other AXIS sink. Used as the on-chip traffic source for bring-up and for exercising frame-mode FIFO drop and overflow paths. Selected frames can be marked bad via tuser, and an optional inter-frame gap can be inserted.

---
 rtl/axis_frame_gen.sv | 191 +++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: programmable length, incrementing byte pattern, optional bad-frame marking and gap.
// Latency: first tvalid one cycle after start is accepted; 1 beat/cycle while tready is high.
// Backpressure: all beat outputs are registered and held stable until the tvalid/tready handshake.
module axis_frame_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH    = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int USER_WIDTH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [LEN_WIDTH-1:0]  cfg_count,
    input  logic [LEN_WIDTH-1:0]  cfg_gap,
    input  logic [LEN_WIDTH-1:0]  cfg_bad_every,
    input  logic [7:0]            cfg_seed,
    input  logic [ID_WIDTH-1:0]   cfg_id,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [7:0]            m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  status_busy,
    output logic [LEN_WIDTH-1:0]  status_frame_count,
    output logic                  status_done
);
    localparam int CW = LEN_WIDTH + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] dat;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic                  bad;
    } beat_t;

    // Lane j of a beat starting at byte offset off carries byte off+j of the frame.
    function automatic beat_t build_beat(input logic [7:0] seed, input logic [CW-1:0] off,
                                         input logic [CW-1:0] len, input logic bad);
        beat_t         b;
        logic [CW-1:0] idx;
        b = '0;
        for (int j = 0; j < KEEP_WIDTH; j++) begin
            idx = off + CW'(j);
            if (idx < len) begin
                b.dat[8*j +: 8] = seed + idx[7:0];
                b.keep[j]       = 1'b1;
            end
        end
        b.last = ({1'b0, off} + (CW+1)'(KEEP_WIDTH)) >= {1'b0, len};
        b.bad  = bad & b.last;
        if (!KEEP_ENABLE) b.keep = '1;
        return b;
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         len_q, len_d, off_q, off_d, gap_cnt_q, gap_cnt_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d, gap_q, gap_d, bad_every_q, bad_every_d;
    logic [LEN_WIDTH-1:0]  bad_cnt_q, bad_cnt_d, frame_count_q, frame_count_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            seed_q, seed_d;
    logic                  stop_pend_q, stop_pend_d, busy_q, busy_d, done_q, done_d;
    logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;

    logic                 load, go_idle, hs, stop_seen, cur_bad, nxt_bad, last_frame;
    logic [LEN_WIDTH-1:0] bad_cnt_nx, fc_inc;
    logic [7:0]           bld_seed;
    logic [CW-1:0]        bld_off, bld_len, start_len;
    logic                 bld_bad;
    beat_t                bld;

    always_comb begin
        state_d = state_q;          len_d = len_q;          off_d = off_q;
        gap_cnt_d = gap_cnt_q;      count_d = count_q;      gap_d = gap_q;
        bad_every_d = bad_every_q;  bad_cnt_d = bad_cnt_q;  frame_count_d = frame_count_q;
        id_d = id_q;                seed_d = seed_q;        stop_pend_d = stop_pend_q;
        busy_d = busy_q;            done_d = 1'b0;          tvalid_d = tvalid_q;
        tlast_d = tlast_q;          tuser_d = tuser_q;      tdata_d = tdata_q;
        tkeep_d = tkeep_q;
        load = 1'b0;  go_idle = 1'b0;
        bld_seed = seed_q;  bld_off = '0;  bld_len = len_q;  bld_bad = 1'b0;

        hs         = tvalid_q & m_axis_tready;
        stop_seen  = stop_pend_q | stop;
        start_len  = (cfg_len == '0) ? ONE : {1'b0, cfg_len};
        // Bad-frame phase is tracked by a modulo counter instead of a divider.
        cur_bad    = (bad_every_q != '0) && ({1'b0, bad_cnt_q} + ONE == {1'b0, bad_every_q});
        bad_cnt_nx = cur_bad ? '0 : bad_cnt_q + LEN_WIDTH'(1);
        nxt_bad    = (bad_every_q != '0) && ({1'b0, bad_cnt_nx} + ONE == {1'b0, bad_every_q});
        fc_inc     = (&frame_count_q) ? frame_count_q : frame_count_q + LEN_WIDTH'(1);
        last_frame = stop_seen ||
                     ((count_q != '0) && ({1'b0, frame_count_q} + ONE == {1'b0, count_q}));

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d = start_len;          count_d = cfg_count;    gap_d = cfg_gap;
                    bad_every_d = cfg_bad_every; id_d = cfg_id;         seed_d = cfg_seed;
                    off_d = '0;  bad_cnt_d = '0;  frame_count_d = '0;
                    busy_d = 1'b1;  stop_pend_d = 1'b0;  state_d = SEND;
                    load = 1'b1;  bld_seed = cfg_seed;  bld_len = start_len;
                    bld_bad = (cfg_bad_every == LEN_WIDTH'(1));
                end
            end
            SEND: begin
                if (stop) stop_pend_d = 1'b1;
                if (hs && !tlast_q) begin
                    off_d = off_q + CW'(KEEP_WIDTH);
                    load = 1'b1;  bld_off = off_q + CW'(KEEP_WIDTH);  bld_bad = cur_bad;
                end else if (hs) begin
                    frame_count_d = fc_inc;  seed_d = seed_q + 8'd1;
                    bad_cnt_d = bad_cnt_nx;  off_d = '0;
                    if (last_frame) begin
                        go_idle = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;  gap_cnt_d = {1'b0, gap_q};
                        tvalid_d = 1'b0;  tlast_d = 1'b0;  tuser_d = 1'b0;
                        tdata_d = '0;  tkeep_d = '0;
                    end else begin
                        load = 1'b1;  bld_seed = seed_q + 8'd1;  bld_bad = nxt_bad;
                    end
                end
            end
            GAP: begin
                if (stop) stop_pend_d = 1'b1;
                if (gap_cnt_q == ONE) begin
                    if (stop_seen) begin
                        go_idle = 1'b1;
                    end else begin
                        state_d = SEND;  load = 1'b1;  bld_bad = cur_bad;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - ONE;
                end
            end
            default: go_idle = 1'b1;
        endcase

        bld = build_beat(bld_seed, bld_off, bld_len, bld_bad);
        if (load) begin
            tvalid_d = 1'b1;  tdata_d = bld.dat;  tkeep_d = bld.keep;
            tlast_d = bld.last;  tuser_d = bld.bad;
        end
        if (go_idle) begin
            state_d = IDLE;  busy_d = 1'b0;  done_d = 1'b1;  stop_pend_d = 1'b0;
            tvalid_d = 1'b0;  tlast_d = 1'b0;  tuser_d = 1'b0;  tdata_d = '0;  tkeep_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;        len_q <= '0;        off_q <= '0;
            gap_cnt_q <= '0;        count_q <= '0;      gap_q <= '0;
            bad_every_q <= '0;      bad_cnt_q <= '0;    frame_count_q <= '0;
            id_q <= '0;             seed_q <= '0;       stop_pend_q <= 1'b0;
            busy_q <= 1'b0;         done_q <= 1'b0;     tvalid_q <= 1'b0;
            tlast_q <= 1'b0;        tuser_q <= 1'b0;    tdata_q <= '0;
            tkeep_q <= '0;
        end else begin
            state_q <= state_d;     len_q <= len_d;     off_q <= off_d;
            gap_cnt_q <= gap_cnt_d; count_q <= count_d; gap_q <= gap_d;
            bad_every_q <= bad_every_d; bad_cnt_q <= bad_cnt_d; frame_count_q <= frame_count_d;
            id_q <= id_d;           seed_q <= seed_d;   stop_pend_q <= stop_pend_d;
            busy_q <= busy_d;       done_q <= done_d;   tvalid_q <= tvalid_d;
            tlast_q <= tlast_d;     tuser_q <= tuser_d; tdata_q <= tdata_d;
            tkeep_q <= tkeep_d;
        end
    end

    assign m_axis_tdata       = tdata_q;
    assign m_axis_tkeep       = tkeep_q;
    assign m_axis_tvalid      = tvalid_q;
    assign m_axis_tlast       = tlast_q;
    assign m_axis_tid         = id_q;
    assign m_axis_tdest       = '0;
    assign m_axis_tuser       = USER_WIDTH'(tuser_q);
    assign status_busy        = busy_q;
    assign status_frame_count = frame_count_q;
    assign status_done        = done_q;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen at DATA_WIDTH=32 (4 byte lanes).
module tb_axis_frame_gen;
    logic        clk = 1'b0;
    logic        rst_n, start, stop, tready;
    logic [15:0] cfg_len, cfg_count, cfg_gap, cfg_bad_every;
    logic [7:0]  cfg_seed, cfg_id;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tvalid, tlast;
    logic [7:0]  tid, tdest;
    logic [0:0]  tuser;
    logic        busy, done;
    logic [15:0] fcount;

    int          n_chk = 0;
    int          n_pass = 0;
    int          pi = 0;
    bit          use_pat = 1'b0;
    logic [15:0] pat = 16'b1001_0110_0100_1001;
    logic [7:0]  s;
    int          n;

    axis_frame_gen #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .cfg_bad_every(cfg_bad_every), .cfg_seed(cfg_seed), .cfg_id(cfg_id),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tid(tid),
        .m_axis_tdest(tdest), .m_axis_tuser(tuser), .status_busy(busy),
        .status_frame_count(fcount), .status_done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (use_pat) begin
            tready = pat[pi];
            pi = (pi + 1) % 16;
        end
    endtask

    task automatic do_start(input logic [15:0] len, input logic [15:0] cnt, input logic [15:0] gap,
                            input logic [15:0] bad, input logic [7:0] seed, input logic [7:0] id);
        cfg_len = len;  cfg_count = cnt;  cfg_gap = gap;  cfg_bad_every = bad;
        cfg_seed = seed;  cfg_id = id;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for a handshake; while stalled the presented beat must already be the expected one.
    task automatic expect_beat(input string tag, input logic [31:0] d, input logic [3:0] k,
                               input logic l, input logic u);
        int w;
        w = 0;
        while (!(tvalid && tready) && w < 64) begin
            if (tvalid) chk({tag, "_hold"}, tdata, d);
            tick();
            w++;
        end
        if (w >= 64) begin
            chk({tag, "_wait"}, 32'(tvalid & tready), 32'd1);
        end else begin
            chk({tag, "_data"}, tdata, d);
            chk({tag, "_keep"}, 32'(tkeep), 32'(k));
            chk({tag, "_last"}, 32'(tlast), 32'(l));
            chk({tag, "_user"}, 32'(tuser), 32'(u));
        end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;  start = 1'b0;  stop = 1'b0;  tready = 1'b1;
        cfg_len = '0;  cfg_count = '0;  cfg_gap = '0;  cfg_bad_every = '0;
        cfg_seed = '0;  cfg_id = '0;
        repeat (3) tick();
        chk("rst_valid", 32'(tvalid), 32'd0);
        chk("rst_busy",  32'(busy),   32'd0);
        chk("rst_done",  32'(done),   32'd0);
        chk("rst_fc",    32'(fcount), 32'd0);
        chk("rst_data",  tdata,       32'd0);
        chk("rst_keep",  32'(tkeep),  32'd0);
        chk("rst_last",  32'(tlast),  32'd0);
        chk("rst_user",  32'(tuser),  32'd0);
        rst_n = 1'b1;
        tick();

        // Two-beat frame with a partial last beat.
        do_start(16'd6, 16'd1, 16'd0, 16'd0, 8'h10, 8'h5A);
        chk("t1_first_valid", 32'(tvalid), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_tid", 32'(tid), 32'h5A);
        chk("t1_tdest", 32'(tdest), 32'd0);
        expect_beat("t1_b0", 32'h13121110, 4'hF, 1'b0, 1'b0);
        expect_beat("t1_b1", 32'h00001514, 4'h3, 1'b1, 1'b0);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_fc", 32'(fcount), 32'd1);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle_valid", 32'(tvalid), 32'd0);

        // Three 3-byte frames with a 2-cycle gap and seed wrap.
        do_start(16'd3, 16'd3, 16'd2, 16'd0, 8'hFE, 8'h33);
        for (int f = 0; f < 3; f++) begin
            s = 8'hFE + 8'(f);
            expect_beat("t2_beat", {8'h00, s + 8'd2, s + 8'd1, s}, 4'h7, 1'b1, 1'b0);
            if (f < 2) begin
                n = 0;
                while (!tvalid && n < 20) begin
                    n++;
                    tick();
                end
                chk("t2_gap", 32'(n), 32'd2);
            end
        end
        chk("t2_busy_end", 32'(busy), 32'd0);
        chk("t2_fc", 32'(fcount), 32'd3);
        tick();

        // First case again under a stalling sink.
        tready = 1'b0;  pi = 0;  use_pat = 1'b1;
        do_start(16'd6, 16'd1, 16'd0, 16'd0, 8'h10, 8'h5A);
        expect_beat("t3_b0", 32'h13121110, 4'hF, 1'b0, 1'b0);
        expect_beat("t3_b1", 32'h00001514, 4'h3, 1'b1, 1'b0);
        use_pat = 1'b0;  tready = 1'b1;
        chk("t3_fc", 32'(fcount), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        tick();

        // Free-running 8-byte frames, every 3rd bad, stop in the middle of frame 5.
        do_start(16'd8, 16'd0, 16'd0, 16'd3, 8'h00, 8'h01);
        for (int f = 0; f < 5; f++) begin
            s = 8'(f);
            expect_beat("t4_b0", {s + 8'd3, s + 8'd2, s + 8'd1, s}, 4'hF, 1'b0, 1'b0);
            if (f == 4) begin
                tready = 1'b0;  stop = 1'b1;
                tick();
                stop = 1'b0;  tready = 1'b1;
            end
            expect_beat("t4_b1", {s + 8'd7, s + 8'd6, s + 8'd5, s + 8'd4}, 4'hF, 1'b1, f == 2);
        end
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_fc", 32'(fcount), 32'd5);
        chk("t4_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_no_more", 32'(tvalid), 32'd0);

        // Zero length becomes one byte; a start while busy must not re-latch cfg.
        do_start(16'd0, 16'd2, 16'd0, 16'd0, 8'h40, 8'h11);
        tready = 1'b0;
        cfg_seed = 8'h99;  cfg_id = 8'h22;  cfg_len = 16'd8;  start = 1'b1;
        tick();
        start = 1'b0;  tready = 1'b1;
        expect_beat("t5_f0", 32'h00000040, 4'h1, 1'b1, 1'b0);
        chk("t5_tid", 32'(tid), 32'h11);
        expect_beat("t5_f1", 32'h00000041, 4'h1, 1'b1, 1'b0);
        chk("t5_fc", 32'(fcount), 32'd2);
        chk("t5_done", 32'(done), 32'd1);
        tick();

        // Asynchronous reset during beat 2 of a 4-beat frame, then a clean restart.
        do_start(16'd16, 16'd1, 16'd0, 16'd0, 8'h20, 8'h07);
        expect_beat("t6_pre", 32'h23222120, 4'hF, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_valid", 32'(tvalid), 32'd0);
        chk("t6_async_last", 32'(tlast), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("t6_fc", 32'(fcount), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        tick();
        do_start(16'd16, 16'd1, 16'd0, 16'd0, 8'h20, 8'h07);
        expect_beat("t6_b0", 32'h23222120, 4'hF, 1'b0, 1'b0);
        expect_beat("t6_b1", 32'h27262524, 4'hF, 1'b0, 1'b0);
        expect_beat("t6_b2", 32'h2B2A2928, 4'hF, 1'b0, 1'b0);
        expect_beat("t6_b3", 32'h2F2E2D2C, 4'hF, 1'b1, 1'b0);
        chk("t6_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
